// File: rtl/display_pkg.sv
// Shared constants, scan FSM state type and anode helpers for the
// multiplexed 4-digit display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [3:0]  AN_OFF     = 4'hF;

  typedef enum logic {
    S_DEAD  = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

  // Active-low one-hot anode pattern for the digit being driven.
  function automatic logic [3:0] an_onehot_n(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // True when digit idx (never digit 0) and every more significant digit is zero.
  function automatic logic lz_blank(input logic [15:0] active, input logic [1:0] idx);
    logic [15:0] upper;
    upper = active >> {idx, 2'b00};
    return (idx != 2'd0) && (upper == 16'h0000);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Period counter: emits a one-cycle tick on the last cycle of each period.
// The period length is an input so one counter serves both DEAD and DRIVE.
module scan_tick_gen #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == (period_i - W'(1)));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // NOTE: state is updated with <= only; mixing blocking assignments into
  // clocked logic creates simulation/synthesis ordering mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with a frame-synchronous value update.
// Define DISPLAY_LZ_BLANK_EN to blank leading-zero digits (digit 0 never blanked).
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIV  = 1000,
  parameter int unsigned DEAD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val_i,
  input  logic        val_valid_i,
  output logic        val_ready_o,
  output logic [3:0]  digit_o,
  output logic [3:0]  an_n_o,
  output logic        frame_o
);

  localparam int unsigned MAX_P = (DIV > DEAD) ? DIV : DEAD;
  localparam int unsigned CNT_W = $clog2(MAX_P + 1);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             boot_q, boot_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             ready_q, ready_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [3:0]       digit_q, digit_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic [CNT_W-1:0] period;
  logic             capture;
  logic             last_digit;
  logic             enter_dead;
  logic             enter_drive;

  assign period = (state_q == S_DEAD) ? CNT_W'(DEAD) : CNT_W'(DIV);

  // The first edge out of reset is itself a boundary, so the counter restarts there.
  scan_tick_gen #(
    .W (CNT_W)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (boot_q),
    .period_i  (period),
    .tick_o    (tick)
  );

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    boot_d       = 1'b0;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ready_d      = ready_q;
    an_n_d       = an_n_q;
    digit_d      = digit_q;
    frame_d      = 1'b0;
    enter_dead   = 1'b0;
    enter_drive  = 1'b0;
    capture      = val_valid_i && ready_q;
    last_digit   = (idx_q == IDX_W'(NUM_DIGITS - 1));

    if (boot_q) begin
      state_d    = S_DEAD;
      idx_d      = '0;
      enter_dead = 1'b1;
      frame_d    = 1'b1;
    end else begin
      unique case (state_q)
        S_DEAD: begin
          if (tick) begin
            state_d     = S_DRIVE;
            enter_drive = 1'b1;
          end
        end
        S_DRIVE: begin
          if (tick) begin
            state_d    = S_DEAD;
            idx_d      = idx_q + IDX_W'(1);
            enter_dead = 1'b1;
            frame_d    = last_digit;
          end
        end
        default: state_d = S_DEAD;
      endcase
    end

    // Commit uses the value pending before this edge; a capture landing on the
    // same boundary therefore waits for the next one.
    if (frame_d && pend_valid_q) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
    end
    if (capture) begin
      pend_d       = val_i;
      pend_valid_d = 1'b1;
    end

    // Ready rises one cycle after the pending slot empties.
    if (capture) begin
      ready_d = 1'b0;
    end else if (!pend_valid_q) begin
      ready_d = 1'b1;
    end

    if (enter_dead) begin
      an_n_d  = AN_OFF;
      digit_d = active_d[{idx_d, 2'b00} +: 4];
    end
    if (enter_drive) begin
      an_n_d = an_onehot_n(idx_q);
`ifdef DISPLAY_LZ_BLANK_EN
      if (lz_blank(active_q, idx_q)) begin
        an_n_d = AN_OFF;
      end
`endif
    end
  end

  // NOTE: all control and output registers take the async reset so anodes go
  // dark immediately; the datapath regs are reset too because the block
  // explicitly shows 0 and accepts a value straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DEAD;
      idx_q        <= '0;
      boot_q       <= 1'b1;
      active_q     <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      an_n_q       <= AN_OFF;
      digit_q      <= 4'h0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      boot_q       <= boot_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ready_q      <= ready_d;
      an_n_q       <= an_n_d;
      digit_q      <= digit_d;
      frame_q      <= frame_d;
    end
  end

  assign val_ready_o = ready_q;
  assign digit_o     = digit_q;
  assign an_n_o      = an_n_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=4, DEAD=2, 24-cycle frame):
// directed tables and sequences plus random updates against a timeline model.
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DIV + DEAD;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] val_i = 16'h0000;
  logic        val_valid_i = 1'b0;
  logic        val_ready_o;
  logic [3:0]  digit_o;
  logic [3:0]  an_n_o;
  logic        frame_o;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DIV  (DIV),
    .DEAD (DEAD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .val_i       (val_i),
    .val_valid_i (val_valid_i),
    .val_ready_o (val_ready_o),
    .digit_o     (digit_o),
    .an_n_o      (an_n_o),
    .frame_o     (frame_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: position in the frame timeline since the boot edge,
  // the displayed value, and a single pending slot.
  int          m_n = -1;
  int          m_rise = -1;
  logic [15:0] m_active = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pend_v = 1'b0;
  bit          m_ready = 1'b1;

  function automatic logic [3:0] exp_an();
    int t, d;
    logic [3:0] one;
    one = 4'b0001;
    if (m_n < 0) return 4'hF;
    t = m_n % FRAME;
    d = t / SLOT;
    if ((t % SLOT) < DEAD) return 4'hF;
`ifdef DISPLAY_LZ_BLANK_EN
    if (d > 0 && (m_active >> (4 * d)) == 16'h0000) return 4'hF;
`endif
    return ~(one << d);
  endfunction

  function automatic logic [3:0] exp_digit();
    int d;
    if (m_n < 0) return 4'h0;
    d = (m_n % FRAME) / SLOT;
    return m_active[4*d +: 4];
  endfunction

  function automatic logic exp_frame();
    return (m_n >= 0) && ((m_n % FRAME) == 0);
  endfunction

  task automatic model_edge();
    bit cap;
    if (!rst_n) begin
      m_n = -1; m_rise = -1; m_active = 16'h0000; m_pend_v = 1'b0; m_ready = 1'b1;
      return;
    end
    cap = val_valid_i && m_ready;
    m_n++;
    if ((m_n % FRAME) == 0 && m_pend_v) begin
      m_active = m_pend;
      m_pend_v = 1'b0;
      m_rise   = m_n + 1;
    end
    if (cap) begin
      m_pend   = val_i;
      m_pend_v = 1'b1;
    end
    m_ready = !m_pend_v && (m_n >= m_rise);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("an_n_o", 32'(an_n_o), 32'(exp_an()));
    check("digit_o", 32'(digit_o), 32'(exp_digit()));
    check("frame_o", 32'(frame_o), 32'(exp_frame()));
    check("val_ready_o", 32'(val_ready_o), 32'(m_ready));
  endtask

  task automatic wait_an(input logic [3:0] target);
    int k;
    k = 0;
    while (an_n_o !== target && k < 100) begin
      tick();
      k++;
    end
    check("wait_an_timeout", 32'(an_n_o), 32'(target));
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (frame_o !== 1'b1 && k < 100);
    check("wait_frame_timeout", 32'(frame_o), 32'(1));
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (val_ready_o !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("wait_ready_timeout", 32'(val_ready_o), 32'(1));
  endtask

  task automatic load(input logic [15:0] v);
    wait_ready();
    val_i = v;
    val_valid_i = 1'b1;
    tick();
    val_valid_i = 1'b0;
    wait_frame();
  endtask

  // Scan one frame from its boundary cycle; report which anodes were ever driven.
  task automatic scan_frame(output logic [3:0] mask, output int driven);
    mask = 4'h0;
    driven = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (an_n_o != 4'hF) driven++;
      mask = mask | ~an_n_o;
      tick();
    end
  endtask

  typedef struct {
    logic [3:0] an;
    logic [3:0] digit;
    int         cycles;
  } scan_vec_t;

  scan_vec_t   scan_tab[8];
  logic [3:0]  abcd_exp[4];
  logic [3:0]  mask;
  int          driven;
  int          k;
  logic [15:0] rv;
  logic [3:0]  one;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    scan_tab[0] = '{4'hF, 4'h4, DEAD};
    scan_tab[1] = '{4'hE, 4'h4, DIV};
    scan_tab[2] = '{4'hF, 4'h3, DEAD};
    scan_tab[3] = '{4'hD, 4'h3, DIV};
    scan_tab[4] = '{4'hF, 4'h2, DEAD};
    scan_tab[5] = '{4'hB, 4'h2, DIV};
    scan_tab[6] = '{4'hF, 4'h1, DEAD};
    scan_tab[7] = '{4'h7, 4'h1, DIV};
    abcd_exp[0] = 4'hD; abcd_exp[1] = 4'hC; abcd_exp[2] = 4'hB; abcd_exp[3] = 4'hA;
    one = 4'b0001;

    // Reset state and frame cadence out of reset.
    repeat (3) tick();
    check("rst_an", 32'(an_n_o), 32'(4'hF));
    check("rst_digit", 32'(digit_o), 32'(4'h0));
    check("rst_ready", 32'(val_ready_o), 32'(1));
    check("rst_frame", 32'(frame_o), 32'(0));
    rst_n = 1'b1;
    tick();
    check("boot_frame", 32'(frame_o), 32'(1));
    for (int f = 0; f < 2; f++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (frame_o !== 1'b1 && k < 100);
      check("frame_period", 32'(k), 32'(FRAME));
    end

    // Table-driven scan of 16'h1234.
    val_i = 16'h1234;
    val_valid_i = 1'b1;
    tick();
    val_valid_i = 1'b0;
    check("cap_ready_low", 32'(val_ready_o), 32'(0));
    wait_frame();
    for (int e = 0; e < 8; e++) begin
      for (int c = 0; c < scan_tab[e].cycles; c++) begin
        check("scan_an", 32'(an_n_o), 32'(scan_tab[e].an));
        check("scan_digit", 32'(digit_o), 32'(scan_tab[e].digit));
        tick();
      end
    end
    check("scan_wrap_frame", 32'(frame_o), 32'(1));

    // Update mid-frame, second request ignored, commit at the boundary.
    wait_an(4'b1011);
    check("pre_upd_digit2", 32'(digit_o), 32'(4'h2));
    val_i = 16'hABCD;
    val_valid_i = 1'b1;
    tick();
    check("upd_ready_low", 32'(val_ready_o), 32'(0));
    val_i = 16'h5555;
    wait_an(4'b0111);
    check("old_digit3", 32'(digit_o), 32'(4'h1));
    wait_frame();
    check("upd_boundary_digit", 32'(digit_o), 32'(4'hD));
    check("upd_boundary_ready", 32'(val_ready_o), 32'(0));
    val_valid_i = 1'b0;
    tick();
    check("upd_ready_rise", 32'(val_ready_o), 32'(1));
    for (int d = 0; d < 4; d++) begin
      wait_an(~(one << d));
      check("abcd_digit", 32'(digit_o), 32'(abcd_exp[d]));
    end

    // Capture on the boundary edge commits one frame later.
    k = 0;
    while (!(m_n >= 0 && (m_n % FRAME) == FRAME - 1) && k < 100) begin
      tick();
      k++;
    end
    val_i = 16'h9876;
    val_valid_i = 1'b1;
    tick();
    val_valid_i = 1'b0;
    check("late_cap_frame", 32'(frame_o), 32'(1));
    check("late_cap_old_digit", 32'(digit_o), 32'(4'hD));
    check("late_cap_ready", 32'(val_ready_o), 32'(0));
    wait_frame();
    check("late_cap_commit", 32'(digit_o), 32'(4'h6));

    // Random updates against the model.
    for (int i = 0; i < 600; i++) begin
      rv = 16'($urandom);
      val_i = rv >> (4 * $urandom_range(0, 3));
      val_valid_i = ($urandom_range(0, 9) < 3);
      tick();
    end
    val_valid_i = 1'b0;

    // Leading-zero behaviour.
    load(16'h0050);
    scan_frame(mask, driven);
`ifdef DISPLAY_LZ_BLANK_EN
    check("lz_0050_mask", 32'(mask), 32'(4'b0011));
    check("lz_0050_cycles", 32'(driven), 32'(2 * DIV));
`else
    check("lz_0050_mask", 32'(mask), 32'(4'b1111));
    check("lz_0050_cycles", 32'(driven), 32'(4 * DIV));
`endif
    load(16'h0000);
    scan_frame(mask, driven);
`ifdef DISPLAY_LZ_BLANK_EN
    check("lz_0000_mask", 32'(mask), 32'(4'b0001));
    check("lz_0000_cycles", 32'(driven), 32'(DIV));
`else
    check("lz_0000_mask", 32'(mask), 32'(4'b1111));
    check("lz_0000_cycles", 32'(driven), 32'(4 * DIV));
`endif

    // Asynchronous reset in the middle of digit 1 DRIVE.
    load(16'h1234);
    wait_an(4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an_n_o), 32'(4'hF));
    check("async_rst_digit", 32'(digit_o), 32'(4'h0));
    check("async_rst_frame", 32'(frame_o), 32'(0));
    check("async_rst_ready", 32'(val_ready_o), 32'(1));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rerst_boot_frame", 32'(frame_o), 32'(1));
    check("rerst_digit", 32'(digit_o), 32'(4'h0));
    repeat (FRAME + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
